// File: rtl/demux5_reg.sv
// Registered 1-to-5 valid/ready stream demultiplexer with a one-entry holding register per channel.
// Optional macro DEMUX5_STRICT_SEL_EN: selects 5..7 are dropped and set a sticky sel_err flag.
module demux5_reg #(
  parameter int WIREWIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         s,
  input  logic [WIREWIDTH:0] i,
  input  logic               i_valid,
  output logic               i_ready,
  output logic [WIREWIDTH:0] o0,
  output logic [WIREWIDTH:0] o1,
  output logic [WIREWIDTH:0] o2,
  output logic [WIREWIDTH:0] o3,
  output logic [WIREWIDTH:0] o4,
  output logic [4:0]         o_valid,
  input  logic [4:0]         o_ready,
  output logic               sel_err
);

  logic [WIREWIDTH:0] data_q [5];
  logic [4:0]         full_q;
  logic [4:0]         full_d;
  logic [4:0]         wr_en;
  logic [2:0]         ch;
  logic               sel_bad;
  logic               accept;

  always_comb begin
    ch = (s > 3'd4) ? 3'd4 : s;
`ifdef DEMUX5_STRICT_SEL_EN
    sel_bad = (s > 3'd4);
`else
    sel_bad = 1'b0;
`endif
    // An illegal select is always accepted so the producer never stalls on it.
    i_ready = sel_bad | ~full_q[ch] | o_ready[ch];
    accept  = i_valid & i_ready;
    wr_en   = '0;
    if (accept && !sel_bad) wr_en[ch] = 1'b1;
    // A drain and a reload of the same channel in one cycle keeps it full.
    full_d  = (full_q & ~o_ready) | wr_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      for (int k = 0; k < 5; k++) data_q[k] <= '0;
    end else begin
      full_q <= full_d;
      for (int k = 0; k < 5; k++) begin
        if (wr_en[k]) data_q[k] <= i;
      end
    end
  end

`ifdef DEMUX5_STRICT_SEL_EN
  logic sel_err_q;
  logic sel_err_d;

  always_comb sel_err_d = sel_err_q | (accept & sel_bad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err_q <= 1'b0;
    else        sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

  assign o_valid = full_q;
  assign o0      = data_q[0];
  assign o1      = data_q[1];
  assign o2      = data_q[2];
  assign o3      = data_q[3];
  assign o4      = data_q[4];

endmodule
